// File: rtl/counter_step_pkg.sv
// Purpose : shared encodings for the counter step arbiter (FSM states, count direction).
// Latency : n/a (constants only).
// Backpressure : n/a.
package counter_step_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Count direction
    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/counter_step_arbiter_tff_r.sv
// Purpose : T flip-flop, one bit of the shared counter.
// Latency : q toggles on the rising clk edge when t=1.
// Backpressure : none.
// Ports   : clk - clock; rst - async active-high reset (q->0); t - toggle enable; q - state.
module tff_r (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/counter_step_arbiter.sv
// Purpose : round-robin arbiter + step controller for a 3-bit T-FF counter shared by two requesters.
// Latency : grant registered on edge E0; steps on E1..E_len; done pulse in the cycle after E_len.
// Backpressure : requesters hold req until their done pulse; the loser waits in IDLE for the next grant.
// Ports   : clk, rst (async active-high); req[1:0]; mode_0/mode_1 (0=up,1=down); len_0/len_1 step counts;
//           abort ends a run early; q counter state; gnt one-hot registered grant; done one-cycle
//           completion pulse; busy high outside IDLE.
module counter_step_arbiter
    import counter_step_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic             mode_0,
    input  logic             mode_1,
    input  logic [LEN_W-1:0] len_0,
    input  logic [LEN_W-1:0] len_1,
    input  logic             abort,
    output logic [2:0]       q,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy
);

    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = '0;

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_rem;
    logic             r_last;
    logic             r_mode;
    logic [1:0]       r_gnt;

    logic             w_req_any;
    logic             w_win;
    logic             w_sel_mode;
    logic [LEN_W-1:0] w_sel_len;
    logic             w_step;
    logic [2:0]       w_t;
    logic [2:0]       w_q;

    // Winner select: a single request wins outright; on a tie the requester
    // that did not win last time goes, which gives strict alternation.
    assign w_req_any = |req;
    always_comb begin
        w_win = 1'b0;
        case (req)
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_last;
            default: w_win = 1'b0;
        endcase
    end

    assign w_sel_mode = w_win ? mode_1 : mode_0;
    assign w_sel_len  = w_win ? len_1  : len_0;

    // abort wins over a pending step; len=0 leaves RUN without stepping.
    assign w_step = (r_state == ST_RUN) && !abort && (r_rem != LEN_ZERO);

    // Toggle enables: a bit flips when all lower bits are 1 (up) or all 0 (down).
    always_comb begin
        w_t = 3'b000;
        if (w_step) begin
            if (r_mode == MODE_DOWN) begin
                w_t = {~w_q[0] & ~w_q[1], ~w_q[0], 1'b1};
            end else begin
                w_t = {w_q[0] & w_q[1], w_q[0], 1'b1};
            end
        end
    end

    tff_r u_tff0 (.clk(clk), .rst(rst), .t(w_t[0]), .q(w_q[0]));
    tff_r u_tff1 (.clk(clk), .rst(rst), .t(w_t[1]), .q(w_q[1]));
    tff_r u_tff2 (.clk(clk), .rst(rst), .t(w_t[2]), .q(w_q[2]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rem   <= LEN_ZERO;
            r_last  <= 1'b1;
            r_mode  <= MODE_UP;
            r_gnt   <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_mode  <= w_sel_mode;
                        r_rem   <= w_sel_len;
                        r_last  <= w_win;
                        r_gnt   <= w_win ? 2'b10 : 2'b01;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_DONE;
                    end else if (r_rem != LEN_ZERO) begin
                        r_rem <= r_rem - LEN_ONE;
                        if (r_rem == LEN_ONE) begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_gnt   <= 2'b00;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= 2'b00;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign q    = w_q;
    assign gnt  = r_gnt;
    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE) ? (r_last ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_counter_step_arbiter.sv
module tb_counter_step_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic       mode_0;
    logic       mode_1;
    logic [3:0] len_0;
    logic [3:0] len_1;
    logic       abort;
    logic [2:0] q;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;

    int checks;
    int errors;

    counter_step_arbiter #(.LEN_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .mode_0 (mode_0),
        .mode_1 (mode_1),
        .len_0  (len_0),
        .len_1  (len_1),
        .abort  (abort),
        .q      (q),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge, then settle before sampling/driving
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // run a full job for one requester with a bounded wait for done
    task automatic do_run(input logic who, input logic mode, input logic [3:0] len);
        bit seen;
        seen = 1'b0;
        req = who ? 2'b10 : 2'b01;
        if (who) begin mode_1 = mode; len_1 = len; end
        else     begin mode_0 = mode; len_0 = len; end
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (done != 2'b00) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL run_timeout: done=%b required a pulse within 40 cycles", done);
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        checks++; if (q !== 3'd0)     begin errors++; $display("FAIL reset_q: got %0d want 0", q); end
        checks++; if (gnt !== 2'b00)  begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", done); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // q=0 -> count up 5 steps
    task automatic test_up_run;
        req = 2'b01; mode_0 = 1'b0; len_0 = 4'd5;
        tick(); // E0
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL up_gnt: got %b want 01", gnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_busy: got %b want 1", busy); end
        checks++; if (q !== 3'd0)    begin errors++; $display("FAIL up_q_e0: got %0d want 0", q); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (q !== 3'(i)) begin errors++; $display("FAIL up_q_step%0d: got %0d want %0d", i, q, i); end
            if (i < 5) begin
                checks++;
                if (done !== 2'b00) begin errors++; $display("FAIL up_done_early%0d: got %b want 00", i, done); end
            end
        end
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL up_done: got %b want 01", done); end
        checks++; if (gnt !== 2'b01)  begin errors++; $display("FAIL up_gnt_done: got %b want 01", gnt); end
        req = 2'b00;
        tick(); // E6
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL up_done_once: got %b want 00", done); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL up_idle: got %b want 0", busy); end
        checks++; if (gnt !== 2'b00)  begin errors++; $display("FAIL up_gnt_clr: got %b want 00", gnt); end
    endtask

    // q=5, len=0: grant, no step, done after E1, idle after E2
    task automatic test_len_zero;
        req = 2'b01; mode_0 = 1'b0; len_0 = 4'd0;
        tick(); // E0
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL len0_gnt: got %b want 01", gnt); end
        tick(); // E1
        checks++; if (q !== 3'd5)     begin errors++; $display("FAIL len0_q: got %0d want 5", q); end
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL len0_done: got %b want 01", done); end
        req = 2'b00;
        tick(); // E2
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL len0_idle: got %b want 0", busy); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL len0_done_once: got %b want 00", done); end
    endtask

    // from q=5 run up 14; after 6 steps q=3, reset asynchronously mid-cycle,
    // then both requesters tie with len=2 up and must alternate 0,1,0
    task automatic test_reset_mid_run_and_fairness;
        req = 2'b01; mode_0 = 1'b0; len_0 = 4'd14;
        tick(); // E0
        for (int i = 0; i < 6; i++) tick();
        checks++; if (q !== 3'd3)    begin errors++; $display("FAIL mid_q_pre: got %0d want 3", q); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (q !== 3'd0)    begin errors++; $display("FAIL mid_rst_q: got %0d want 0", q); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL mid_rst_gnt: got %b want 00", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        req = 2'b11; mode_0 = 1'b0; mode_1 = 1'b0; len_0 = 4'd2; len_1 = 4'd2;
        #1;
        rst = 1'b0;
        tick(); // grant 1
        checks++; if (gnt !== 2'b01)  begin errors++; $display("FAIL fair_gnt1: got %b want 01", gnt); end
        tick(); tick();
        checks++; if (q !== 3'd2)     begin errors++; $display("FAIL fair_q1: got %0d want 2", q); end
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL fair_done1: got %b want 01", done); end
        tick(); // back to IDLE
        checks++; if (gnt !== 2'b00)  begin errors++; $display("FAIL fair_gap1: got %b want 00", gnt); end
        tick(); // grant 2
        checks++; if (gnt !== 2'b10)  begin errors++; $display("FAIL fair_gnt2: got %b want 10", gnt); end
        tick(); tick();
        checks++; if (q !== 3'd4)     begin errors++; $display("FAIL fair_q2: got %0d want 4", q); end
        checks++; if (done !== 2'b10) begin errors++; $display("FAIL fair_done2: got %b want 10", done); end
        tick(); tick(); // IDLE, then grant 3
        checks++; if (gnt !== 2'b01)  begin errors++; $display("FAIL fair_gnt3: got %b want 01", gnt); end
        tick(); tick();
        checks++; if (q !== 3'd6)     begin errors++; $display("FAIL fair_q3: got %0d want 6", q); end
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL fair_done3: got %b want 01", done); end
        req = 2'b00;
        tick();
    endtask

    // bring q from 6 to 1, then requester 1 counts down 3 from q=1: 0,7,6
    task automatic test_down_wrap;
        do_run(1'b0, 1'b0, 4'd3);
        checks++; if (q !== 3'd1) begin errors++; $display("FAIL down_setup_q: got %0d want 1", q); end
        req = 2'b10; mode_1 = 1'b1; len_1 = 4'd3;
        tick(); // E0
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL down_gnt: got %b want 10", gnt); end
        mode_1 = 1'b0; // must be ignored after grant
        len_1  = 4'd9;
        tick();
        checks++; if (q !== 3'd0) begin errors++; $display("FAIL down_q1: got %0d want 0", q); end
        tick();
        checks++; if (q !== 3'd7) begin errors++; $display("FAIL down_q2: got %0d want 7", q); end
        tick();
        checks++; if (q !== 3'd6)     begin errors++; $display("FAIL down_q3: got %0d want 6", q); end
        checks++; if (done !== 2'b10) begin errors++; $display("FAIL down_done: got %b want 10", done); end
        req = 2'b00;
        tick();
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL down_done_once: got %b want 00", done); end
        checks++; if (q !== 3'd6)     begin errors++; $display("FAIL down_q_hold: got %0d want 6", q); end
    endtask

    // q 6 -> 0, then len=6 up with abort in the cycle before E3
    task automatic test_abort;
        do_run(1'b0, 1'b0, 4'd2);
        checks++; if (q !== 3'd0) begin errors++; $display("FAIL abort_setup_q: got %0d want 0", q); end
        abort = 1'b1; // no effect in IDLE
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b want 0", busy); end
        abort = 1'b0;
        req = 2'b01; mode_0 = 1'b0; len_0 = 4'd6;
        tick(); // E0
        tick(); tick(); // E1, E2
        checks++; if (q !== 3'd2) begin errors++; $display("FAIL abort_q_pre: got %0d want 2", q); end
        abort = 1'b1;
        tick(); // E3
        abort = 1'b0;
        checks++; if (q !== 3'd2)     begin errors++; $display("FAIL abort_q: got %0d want 2", q); end
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL abort_done: got %b want 01", done); end
        req = 2'b00;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_after: got %b want 0", busy); end
        checks++; if (q !== 3'd2)    begin errors++; $display("FAIL abort_q_after: got %0d want 2", q); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        req = 2'b00; mode_0 = 1'b0; mode_1 = 1'b0;
        len_0 = 4'd0; len_1 = 4'd0; abort = 1'b0;
        test_reset();
        test_up_run();
        test_len_zero();
        test_reset_mid_run_and_fairness();
        test_down_wrap();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
